// File: rtl/chi_step_folded_pkg.sv
// Shared types and constants for the folded chi step.
//   ROW_SIZE / COL_SIZE : Keccak state plane dimensions (x and y).
//   LANE_W_MAX          : widest lane supported by Keccak-f (w = 64).
//   chi_fsm_t           : controller state, also exported as a debug output.
//   chi_slice_bits()    : bit count of one 5x5xCHUNK_W slice.
package chi_step_folded_pkg;

  localparam int ROW_SIZE   = 5;
  localparam int COL_SIZE   = 5;
  localparam int LANE_W_MAX = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chi_fsm_t;

  // Size of a [ROW_SIZE][COL_SIZE][chunk_w] slice. Slice types themselves are
  // declared where CHUNK_W is known, so their width is checked against this.
  function automatic int chi_slice_bits(input int chunk_w);
    return ROW_SIZE * COL_SIZE * chunk_w;
  endfunction

endpackage

// File: rtl/chi_step_folded_if.sv
// Handshake bundle around the folded chi step.
//   clear_i        : synchronous abort towards the block.
//   valid_i/ready_o: input state handshake; state_array_i indexed [x][y][z].
//   valid_o/ready_i: result handshake; state_array_o indexed [x][y][z].
//   busy_o         : block is holding a state (computing or waiting to hand off).
// Handshake rule for both directions: a transfer happens on a rising clk edge
// where valid and ready are both high; valid may not depend on ready, data is
// held stable while valid is high and ready is low.
interface chi_step_folded_if
  import chi_step_folded_pkg::*;
#(
  parameter int LANE_W = 64
);

  logic                                          clear_i;
  logic                                          valid_i;
  logic                                          ready_o;
  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_W-1:0] state_array_i;
  logic                                          valid_o;
  logic                                          ready_i;
  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_W-1:0] state_array_o;
  logic                                          busy_o;

  modport slave (
    input  clear_i, valid_i, state_array_i, ready_i,
    output ready_o, valid_o, state_array_o, busy_o
  );

  modport master (
    output clear_i, valid_i, state_array_i, ready_i,
    input  ready_o, valid_o, state_array_o, busy_o
  );

endinterface

// File: rtl/chi_step_folded_slice.sv
// Purely combinational chi over a 5x5xCHUNK_W slice of the state.
//   slice_i : input slice, indexed [x][y][z]
//   slice_o : slice_i[x][y] ^ (~slice_i[x+1][y] & slice_i[x+2][y]), x mod 5
module chi_slice
  import chi_step_folded_pkg::*;
#(
  parameter int CHUNK_W = 16
) (
  input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][CHUNK_W-1:0] slice_i,
  output logic [ROW_SIZE-1:0][COL_SIZE-1:0][CHUNK_W-1:0] slice_o
);

  for (genvar x = 0; x < ROW_SIZE; x++) begin : g_x
    for (genvar y = 0; y < COL_SIZE; y++) begin : g_y
      // Neighbours wrap within row y; z bits never interact.
      assign slice_o[x][y] = slice_i[x][y] ^
                             (~slice_i[(x + 1) % ROW_SIZE][y] & slice_i[(x + 2) % ROW_SIZE][y]);
    end
  end

endmodule

// File: rtl/chi_step_folded.sv
// Folded Keccak chi step: the 5x5xLANE_W state is processed CHUNK_W z-bits
// per cycle, in place inside a work register.
//   clk, rst_n  : clock (rising edge) and asynchronous active-low reset
//   bus         : chi_step_folded_if slave (input/result handshakes, clear, busy)
//   dbg_state_o : current controller state
// Latency is NUM_CHUNKS edges from accept to valid_o; a result handed off while
// a new input is waiting reloads in the same cycle with no bubble.
module chi_step_folded
  import chi_step_folded_pkg::*;
#(
  parameter int LANE_W  = 64,
  parameter int CHUNK_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  chi_step_folded_if.slave bus,
  output chi_fsm_t         dbg_state_o
);

  localparam int NUM_CHUNKS = LANE_W / CHUNK_W;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  if ((CHUNK_W < 1) || ((LANE_W % CHUNK_W) != 0)) begin : g_bad_chunk
    $error("chi_step_folded: CHUNK_W (%0d) must divide LANE_W (%0d)", CHUNK_W, LANE_W);
  end

  // The work register is viewed as chunks so the active chunk is selected by
  // the counter directly. Packed layout matches [x][y][LANE_W-1:0], chunk k
  // covering z bits [k*CHUNK_W +: CHUNK_W].
  typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][NUM_CHUNKS-1:0][CHUNK_W-1:0] work_t;
  typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][CHUNK_W-1:0]                 slice_t;

  if ($bits(slice_t) != chi_slice_bits(CHUNK_W)) begin : g_bad_slice
    $error("chi_step_folded: slice type width mismatch");
  end

  chi_fsm_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  work_t            work_q, work_d;
  slice_t           slice_in, slice_out;
  logic             ready, accept, last_chunk;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  // Chunk mux: the counter picks the z-chunk fed through chi this cycle.
  always_comb begin
    slice_in = '0;
    for (int x = 0; x < ROW_SIZE; x++) begin
      for (int y = 0; y < COL_SIZE; y++) begin
        slice_in[x][y] = work_q[x][y][cnt_q];
      end
    end
  end

  chi_slice #(.CHUNK_W(CHUNK_W)) u_chi_slice (
    .slice_i (slice_in),
    .slice_o (slice_out)
  );

  assign last_chunk = (cnt_q == CNT_W'(NUM_CHUNKS - 1));
  // clear_i wins over any handshake, so an input beside it is never taken.
  assign accept     = bus.valid_i && ready && !bus.clear_i;

  // Next-state logic, including the in-place chunk write-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    if (bus.clear_i) begin
      // Abort keeps the work register; only control returns to IDLE.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            work_d  = work_t'(bus.state_array_i);
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          for (int x = 0; x < ROW_SIZE; x++) begin
            for (int y = 0; y < COL_SIZE; y++) begin
              work_d[x][y][cnt_q] = slice_out[x][y];
            end
          end
          if (last_chunk) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.ready_i) begin
            if (accept) begin
              work_d  = work_t'(bus.state_array_i);
              cnt_d   = '0;
              state_d = RUN;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs: ready depends on state and ready_i only, never on valid_i.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      IDLE:    ready = 1'b1;
      DONE:    ready = bus.ready_i;
      default: ready = 1'b0;
    endcase
  end

  assign bus.ready_o       = ready;
  assign bus.valid_o       = (state_q == DONE);
  assign bus.busy_o        = (state_q == RUN) || (state_q == DONE);
  assign bus.state_array_o = work_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_chi_step_folded.sv
module tb_chi_step_folded;
  import chi_step_folded_pkg::*;

  typedef logic [4:0][4:0][63:0] st_t;

  localparam int NCFG = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n      = 1'b0;
  logic rst_main_n = 1'b0;
  int   cyc        = 0;
  always @(posedge clk) cyc++;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_done = 0;

  // ---------------- reference model and helpers ----------------
  function automatic logic [63:0] lane_mask(input int lw);
    logic [63:0] one;
    one = 64'd1;
    return (lw >= 64) ? '1 : ((one << lw) - 64'd1);
  endfunction

  function automatic st_t chi_ref(input st_t a, input int lw);
    st_t r;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[x][y] = (a[x][y] ^ (~a[(x + 1) % 5][y] & a[(x + 2) % 5][y])) & lane_mask(lw);
    return r;
  endfunction

  function automatic st_t rand_state(input int lw);
    st_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) begin
        s[x][y] = {$urandom, $urandom} & lane_mask(lw);
        if ($urandom_range(0, 7) == 0) s[x][y] = s[x][y] & {$urandom, $urandom};
      end
    return s;
  endfunction

  function automatic int cfg_lw(input int g);
    return (g < 3) ? 64 : 8;
  endfunction

  function automatic int cfg_cw(input int g);
    case (g)
      0:       return 1;
      1:       return 4;
      2:       return 64;
      3:       return 1;
      4:       return 4;
      default: return 8;
    endcase
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_st(input string name, input st_t act, input st_t exp);
    bit shown;
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      shown = 0;
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          if (!shown && act[x][y] !== exp[x][y]) begin
            shown = 1;
            $display("FAIL %s: lane[%0d][%0d] got %h expected %h (t=%0t)",
                     name, x, y, act[x][y], exp[x][y], $time);
          end
    end
  endtask

  task automatic fail_event(input string name, input string msg);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", name, msg, $time);
  endtask

  // ---------------- main DUT: LANE_W=64, CHUNK_W=16 ----------------
  chi_step_folded_if #(.LANE_W(64)) m_if ();
  chi_fsm_t m_dbg;

  chi_step_folded #(.LANE_W(64), .CHUNK_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_main_n),
    .bus         (m_if),
    .dbg_state_o (m_dbg)
  );

  logic [1599:0] m_exp_q[$];
  int            m_acc_q[$];
  logic          m_prev_valid = 1'b0;
  logic          m_rand_ready = 1'b0;

  always @(posedge clk) begin
    #1;
    if (m_rand_ready) m_if.ready_i = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard monitor: latency on each valid_o rise, data on each handoff.
  always @(negedge clk) begin
    if (rst_main_n) begin
      if (m_if.valid_o && !m_prev_valid) begin
        if (m_acc_q.size() == 0) fail_event("m_latency", "valid_o rose with no accepted input");
        else check_val("m_latency", cyc - m_acc_q.pop_front(), 4);
      end
      if (m_if.valid_o && m_if.ready_i) begin
        if (m_exp_q.size() == 0) fail_event("m_result", "result handed off with nothing expected");
        else check_st("m_result", m_if.state_array_o, m_exp_q.pop_front());
      end
    end
    m_prev_valid = m_if.valid_o;
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic m_send(input st_t s, input st_t e);
    int guard;
    guard = 0;
    m_if.state_array_i = s;
    m_if.valid_i = 1'b1;
    @(negedge clk);
    while (!m_if.ready_o && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!m_if.ready_o) fail_event("m_send", "input never accepted");
    else begin
      m_exp_q.push_back(e);
      m_acc_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    m_if.valid_i = 1'b0;
  endtask

  task automatic m_drain();
    int guard;
    guard = 0;
    while (m_exp_q.size() != 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (m_exp_q.size() != 0) fail_event("m_drain", "expected results never appeared");
    @(posedge clk);
    #1;
  endtask

  initial begin : main_seq
    st_t s, s2, e;
    int  guard;
    m_if.clear_i       = 1'b0;
    m_if.valid_i       = 1'b0;
    m_if.ready_i       = 1'b1;
    m_if.state_array_i = '0;
    repeat (3) @(negedge clk);
    rst_n      = 1'b1;
    rst_main_n = 1'b1;

    // Reset values
    @(negedge clk);
    check_val("reset_ready", m_if.ready_o, 1);
    check_val("reset_valid", m_if.valid_o, 0);
    check_val("reset_busy", m_if.busy_o, 0);
    check_val("reset_state", m_dbg, IDLE);
    check_st("reset_out", m_if.state_array_o, '0);
    @(posedge clk);
    #1;

    // All zeros, then all ones
    m_send('0, '0);
    @(negedge clk);
    check_val("run_ready", m_if.ready_o, 0);
    check_val("run_busy", m_if.busy_o, 1);
    @(posedge clk);
    #1;
    s = '1;
    m_send(s, s);

    // Single lane A[2][0] set
    s = '0;
    s[2][0] = '1;
    e = '0;
    e[0][0] = '1;
    e[2][0] = '1;
    m_send(s, e);

    // Backpressure for 10 cycles, then handoff with same-cycle reload
    m_drain();
    m_if.ready_i = 1'b0;
    s = rand_state(64);
    m_send(s, chi_ref(s, 64));
    guard = 0;
    @(negedge clk);
    while (!m_if.valid_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_val("bp_valid_rise", m_if.valid_o, 1);
    for (int i = 0; i < 10; i++) begin
      check_val("bp_valid_hold", m_if.valid_o, 1);
      check_val("bp_ready_low", m_if.ready_o, 0);
      check_st("bp_data_hold", m_if.state_array_o, chi_ref(s, 64));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    m_if.ready_i = 1'b1;
    s2 = rand_state(64);
    m_send(s2, chi_ref(s2, 64));
    @(negedge clk);
    check_val("handoff_no_bubble", m_dbg, RUN);
    check_val("handoff_valid_low", m_if.valid_o, 0);

    // clear_i at counter = 2
    m_drain();
    s = rand_state(64);
    m_send(s, chi_ref(s, 64));
    repeat (2) @(posedge clk);
    #1;
    check_val("clr_in_run", m_dbg, RUN);
    m_if.clear_i = 1'b1;
    @(posedge clk);
    #1;
    m_if.clear_i = 1'b0;
    void'(m_exp_q.pop_back());
    void'(m_acc_q.pop_back());
    @(negedge clk);
    check_val("clr_to_idle", m_dbg, IDLE);
    check_val("clr_ready", m_if.ready_o, 1);
    // input beside clear_i must not be taken
    @(posedge clk);
    #1;
    m_if.clear_i       = 1'b1;
    m_if.valid_i       = 1'b1;
    m_if.state_array_i = rand_state(64);
    @(posedge clk);
    #1;
    m_if.clear_i = 1'b0;
    m_if.valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("clr_no_accept", m_dbg, IDLE);
      check_val("clr_no_valid", m_if.valid_o, 0);
    end
    @(posedge clk);
    #1;
    s = rand_state(64);
    m_send(s, chi_ref(s, 64));
    m_drain();

    // Asynchronous reset mid-RUN
    s = rand_state(64);
    m_send(s, chi_ref(s, 64));
    @(posedge clk);
    #3;
    rst_main_n = 1'b0;
    #1;
    check_val("arst_valid", m_if.valid_o, 0);
    check_val("arst_ready", m_if.ready_o, 1);
    check_val("arst_busy", m_if.busy_o, 0);
    check_st("arst_out", m_if.state_array_o, '0);
    void'(m_exp_q.pop_back());
    void'(m_acc_q.pop_back());
    @(negedge clk);
    rst_main_n = 1'b1;
    @(posedge clk);
    #1;
    s = rand_state(64);
    m_send(s, chi_ref(s, 64));
    m_drain();

    // Random traffic with random downstream stalls
    m_rand_ready = 1'b1;
    for (int tx = 0; tx < 1000; tx++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      s = rand_state(64);
      m_send(s, chi_ref(s, 64));
    end
    m_rand_ready = 1'b0;
    @(posedge clk);
    #2;
    m_if.ready_i = 1'b1;
    m_drain();

    guard = 0;
    while (n_done < NCFG && guard < 60000) begin
      @(negedge clk);
      guard++;
    end
    if (n_done < NCFG) fail_event("cfg_done", "other configurations did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // ---------------- extra configurations, random traffic ----------------
  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int LW  = cfg_lw(g);
    localparam int CW  = cfg_cw(g);
    localparam int NC  = LW / CW;
    localparam int NTX = ((20000 / (NC + 1)) < 1000) ? (20000 / (NC + 1)) : 1000;

    chi_step_folded_if #(.LANE_W(LW)) bif ();
    chi_fsm_t      dbg;
    st_t           out_w;
    logic [1599:0] exp_q[$];
    int            acc_q[$];
    logic          prev_valid = 1'b0;

    chi_step_folded #(.LANE_W(LW), .CHUNK_W(CW)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bif),
      .dbg_state_o (dbg)
    );

    always_comb begin
      out_w = '0;
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          out_w[x][y][LW-1:0] = bif.state_array_o[x][y];
    end

    always @(posedge clk) begin
      #1;
      bif.ready_i = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
      if (rst_n) begin
        if (bif.valid_o && !prev_valid) begin
          if (acc_q.size() == 0)
            fail_event($sformatf("cfg%0d_latency", g), "valid_o rose with no accepted input");
          else
            check_val($sformatf("cfg%0d_latency", g), cyc - acc_q.pop_front(), NC);
        end
        if (bif.valid_o && bif.ready_i) begin
          if (exp_q.size() == 0)
            fail_event($sformatf("cfg%0d_result", g), "result handed off with nothing expected");
          else
            check_st($sformatf("cfg%0d_result", g), out_w, exp_q.pop_front());
        end
      end
      prev_valid = bif.valid_o;
    end

    initial begin
      st_t s, e;
      int  guard;
      bif.clear_i       = 1'b0;
      bif.valid_i       = 1'b0;
      bif.ready_i       = 1'b1;
      bif.state_array_i = '0;
      wait (rst_n === 1'b1);
      @(posedge clk);
      #1;
      for (int tx = 0; tx < NTX; tx++) begin
        if (tx == 0) begin
          s = '0;
          s[2][0][LW-1:0] = '1;
          e = '0;
          e[0][0][LW-1:0] = '1;
          e[2][0][LW-1:0] = '1;
        end else begin
          s = rand_state(LW);
          e = chi_ref(s, LW);
        end
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        for (int x = 0; x < 5; x++)
          for (int y = 0; y < 5; y++)
            bif.state_array_i[x][y] = s[x][y][LW-1:0];
        bif.valid_i = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!bif.ready_o && guard < 1000) begin
          @(negedge clk);
          guard++;
        end
        if (!bif.ready_o) fail_event($sformatf("cfg%0d_send", g), "input never accepted");
        else begin
          exp_q.push_back(e);
          acc_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        bif.valid_i = 1'b0;
      end
      guard = 0;
      while (exp_q.size() != 0 && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      if (exp_q.size() != 0) fail_event($sformatf("cfg%0d_drain", g), "expected results never appeared");
      n_done++;
    end
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #900000;
    fail_event("watchdog", "simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/chi_step_folded.md
Name: chi_step_folded

Overview:
Sequential, width-parametrised successor to the combinational chi step of the Keccak permutation. It applies A'[x,y] = A[x,y] xor ((not A[(x+1) mod 5,y]) and A[(x+2) mod 5,y]) to a full 5x5xLANE_W state. Because chi is independent along z, the lane depth is processed CHUNK_W bits per cycle, so area can be traded against latency. It sits between the pi stage and iota in the round datapath and uses a valid/ready handshake on input and output.

Parameters:
LANE_W, 64, lane width w in bits; one of 1, 2, 4, 8, 16, 32, 64 (Keccak-f[25w]).
CHUNK_W, 16, z-bits processed per cycle; must divide LANE_W, and an elaboration-time check fails otherwise.
NUM_CHUNKS, LANE_W/CHUNK_W, derived localparam giving cycles per state.
CNT_W, max(1,$clog2(NUM_CHUNKS)), derived localparam giving chunk counter width.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
clear_i  input  1  synchronous abort; returns the block to IDLE.
valid_i  input  1  input state valid.
ready_o  output  1  block can accept an input state.
state_array_i  input  [ROW_SIZE][COL_SIZE][LANE_W]  input state, indexed [x][y][z].
valid_o  output  1  result valid.
ready_i  input  1  downstream accepts the result.
state_array_o  output  [ROW_SIZE][COL_SIZE][LANE_W]  result state, indexed [x][y][z].
busy_o  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- On reset:
  - state = IDLE, counter = 0, work register = 0.
  - valid_o = 0, busy_o = 0, ready_o = 1, state_array_o = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready_o = 1.
  - On valid_i && ready_o: load the work register from state_array_i, counter <= 0, go to RUN.
- RUN:
  - ready_o = 0.
  - Each cycle, chunk k = counter, covering bits [k*CHUNK_W +: CHUNK_W] of all 25 lanes.
  - The chunk is read from the work register, passed through chi, and written back in place. Other bits are held.
  - The x+1 and x+2 indices wrap modulo 5 within row y. There is no interaction across z.
  - If counter == NUM_CHUNKS-1, go to DONE; otherwise counter += 1.
- DONE:
  - valid_o = 1 and state_array_o = work register, held stable until the handshake.
  - On valid_o && ready_i the result is consumed.
  - If valid_i is also high in that cycle (ready_o = ready_i in DONE), the new state is loaded and the block goes to RUN with zero bubble. Otherwise it goes to IDLE.
- Latency: valid_o first rises NUM_CHUNKS clock edges after the accepting edge. Throughput is one state per NUM_CHUNKS+1 cycles when the downstream never stalls. With NUM_CHUNKS = 1, latency is 1.
- state_array_o always reflects the work register. It is only meaningful while valid_o = 1.
- Backpressure: with ready_i low, DONE holds indefinitely, valid_o stays high, and data is stable.
- clear_i:
  - Takes priority over all handshakes.
  - Next state is IDLE, counter = 0, valid_o = 0.
  - The work register is not cleared.
  - An input presented in the same cycle as clear_i is not accepted.
- rst_n asserted mid-RUN or mid-DONE: outputs immediately take their reset values and the in-flight state is discarded.
- ready_o is combinational from state and ready_i only, never from valid_i.

Decomposition:
- keccak_pkg:
  - Already holds ROW_SIZE = 5 and COL_SIZE = 5.
  - Add typedef enum chi_fsm_t {IDLE, RUN, DONE}.
  - Add a parametrised slice type helper for [5][5][CHUNK_W].
- One natural sub-module, chi_slice: purely combinational chi over a 5x5xCHUNK_W slice, instantiated once.
- chi_step_folded holds the FSM, counter, work register, and the chunk mux/demux.

Test Plan:
- All-zero state, LANE_W=64, CHUNK_W=16 -> valid_o rises exactly 4 edges after accept; output is all zero. All-ones state -> output is all ones.
- A[2][0] = 64'hFFFF_FFFF_FFFF_FFFF, all other lanes 0 -> A'[0][0] = all ones, A'[2][0] = all ones, every other lane 0. Repeat with CHUNK_W = 64 (latency 1) and CHUNK_W = 1 (latency 64) -> identical result.
- Random states (1000 of them) for LANE_W in {8, 64} and CHUNK_W in {1, 4, LANE_W}, checked against a reference chi model -> bit-exact.
- ready_i held low for 10 cycles in DONE -> valid_o stays high, output stable, ready_o = 0. Then ready_i = 1 with valid_i = 1 -> handoff and new load in the same cycle, next result after 4 more edges.
- clear_i pulsed at RUN counter = 2 -> IDLE next cycle, valid_o never rises. A following input completes normally with the correct value.
- rst_n dropped asynchronously mid-RUN -> outputs reset immediately: valid_o = 0, ready_o = 1, state_array_o = 0.
